// File: rtl/uart_pkg.sv
// uart_pkg: shared UART state type, defaults, parity modes and a saturating counter helper
package uart_pkg;
  typedef enum logic {S_OFF = 1'b0, S_RUN = 1'b1} state_t;
  localparam int DEFAULT_DATA_BITS = 8;
  localparam int OVERSAMPLE_RATE = 16;
  localparam int DEFAULT_DIV_WIDTH = 16;
  localparam logic [1:0] NONE = 2'd0;
  localparam logic [1:0] ODD = 2'd1;
  localparam logic [1:0] EVEN = 2'd2;
  function automatic logic [7:0] sat_inc(input logic [7:0] c, input logic inc, input logic clr);
    return clr ? {7'd0, inc} : (inc && c != 8'hFF) ? c + 8'd1 : c;
  endfunction
endpackage

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: synchronous frame FIFO with level, full and empty
module uart_rx_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wr_en,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   rd_en,
  output logic [WIDTH-1:0]       rd_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_wr, do_rd;
  assign empty = level == '0;
  assign full = level == LW'(DEPTH);
  assign do_rd = rd_en && !empty;
  assign do_wr = wr_en && (!full || do_rd);
  assign rd_data = mem[rd_ptr];
  // storage and pointers; pointers wrap naturally since DEPTH is a power of 2
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      level <= '0;
    end else begin
      if (do_wr) mem[wr_ptr] <= wr_data;
      wr_ptr <= wr_ptr + AW'(do_wr);
      rd_ptr <= rd_ptr + AW'(do_rd);
      level <= level + LW'(do_wr) - LW'(do_rd);
    end
endmodule

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: baud tick generation, parity pairing, frame FIFO and event counters for uart_rx
// Idle timeout output is built only when UART_RX_CTRL_TIMEOUT_EN is defined.
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int DATA_BITS = DEFAULT_DATA_BITS,
  parameter int FIFO_DEPTH = 4,
  parameter int DIV_WIDTH = DEFAULT_DIV_WIDTH,
  parameter int TIMEOUT_TICKS = 640
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          cfg_enable,
  input  logic [DIV_WIDTH-1:0]          cfg_divisor,
  input  logic                          clr_counters,
  output logic                          baud_clk_tick,
  input  logic [DATA_BITS-1:0]          rx_data_in,
  input  logic                          rx_done_tick_in,
  input  logic                          parity_err_in,
  output logic [DATA_BITS-1:0]          m_data,
  output logic                          m_parity_flag,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [7:0]                    overrun_cnt,
  output logic [7:0]                    parity_err_cnt,
  output logic                          rx_timeout
);
  state_t state, state_n;
  logic [DIV_WIDTH-1:0] cnt, cnt_n;
  logic run, done, perr, pend, pbit, pop, push, drop, full, empty;
  logic [DATA_BITS:0] head;
  // state, baud counter, pending parity flag and saturating event counters
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= S_OFF;
      cnt <= '0;
      pend <= 1'b0;
      overrun_cnt <= '0;
      parity_err_cnt <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      pend <= run && !done && pbit;
      overrun_cnt <= sat_inc(overrun_cnt, drop, clr_counters);
      parity_err_cnt <= sat_inc(parity_err_cnt, done && pbit, clr_counters);
    end
  // next state, baud tick and frame event decode; events are ignored while off
  always_comb begin
    state_n = cfg_enable ? S_RUN : S_OFF;
    run = state == S_RUN;
    baud_clk_tick = run && cnt >= cfg_divisor;
    cnt_n = (!run || baud_clk_tick) ? '0 : cnt + 1'b1;
    done = run && rx_done_tick_in;
    perr = run && parity_err_in;
    pbit = pend || perr;
    pop = !empty && m_ready;
    push = done && (!full || pop);
    drop = done && !push;
  end
  uart_rx_fifo #(.WIDTH(DATA_BITS + 1), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .reset(reset),
    .wr_en(push),
    .wr_data({pbit, rx_data_in}),
    .rd_en(pop),
    .rd_data(head),
    .full(full),
    .empty(empty),
    .level(fifo_level)
  );
  assign m_valid = !empty;
  assign m_data = head[DATA_BITS-1:0];
  assign m_parity_flag = head[DATA_BITS];
`ifdef UART_RX_CTRL_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_TICKS + 1);
  logic [TW-1:0] tcnt;
  // idle timer: counts baud ticks while frames sit unread, saturating at the limit
  always_ff @(posedge clk or posedge reset)
    if (reset) tcnt <= '0;
    else if (push || pop || empty) tcnt <= '0;
    else if (baud_clk_tick && tcnt != TW'(TIMEOUT_TICKS)) tcnt <= tcnt + 1'b1;
  assign rx_timeout = tcnt == TW'(TIMEOUT_TICKS);
`else
  assign rx_timeout = 1'b0;
`endif
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb_uart_rx_ctrl: directed and random checks of uart_rx_ctrl against a queue-based frame model
module tb_uart_rx_ctrl;
  localparam int DB = 8;
  localparam int D = 4;
  localparam int DW = 16;
  logic clk = 1'b0;
  logic reset, cfg_enable, clr_counters, baud_clk_tick, rx_done_tick_in, parity_err_in;
  logic m_parity_flag, m_valid, m_ready, rx_timeout;
  logic [DW-1:0] cfg_divisor;
  logic [DB-1:0] rx_data_in, m_data;
  logic [2:0] fifo_level;
  logic [7:0] overrun_cnt, parity_err_cnt;
  int n_chk = 0, n_fail = 0;
  logic [8:0] q[$];
  int ovr_m = 0, par_m = 0;
  bit pend_m = 0, run_m = 0;

  always #5 clk = ~clk;

  uart_rx_ctrl dut (
    .clk(clk), .reset(reset), .cfg_enable(cfg_enable), .cfg_divisor(cfg_divisor),
    .clr_counters(clr_counters), .baud_clk_tick(baud_clk_tick), .rx_data_in(rx_data_in),
    .rx_done_tick_in(rx_done_tick_in), .parity_err_in(parity_err_in), .m_data(m_data),
    .m_parity_flag(m_parity_flag), .m_valid(m_valid), .m_ready(m_ready),
    .fifo_level(fifo_level), .overrun_cnt(overrun_cnt), .parity_err_cnt(parity_err_cnt),
    .rx_timeout(rx_timeout)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    run_m = cfg_enable && !reset;
    if (!run_m) pend_m = 0;
  endtask

  task automatic check_state();
    chk("valid", m_valid, q.size() != 0);
    chk("level", fifo_level, q.size());
    if (q.size() != 0) begin
      chk("head_data", m_data, q[0][7:0]);
      chk("head_flag", m_parity_flag, q[0][8]);
    end
    chk("overrun_cnt", overrun_cnt, ovr_m);
    chk("parity_cnt", parity_err_cnt, par_m);
`ifndef UART_RX_CTRL_TIMEOUT_EN
    chk("rx_timeout", rx_timeout, 0);
`endif
  endtask

  task automatic step(input bit d, input bit pe, input bit rdy, input logic [7:0] dat, input bit clr);
    bit popm, acc, pb;
    rx_done_tick_in = d; parity_err_in = pe; m_ready = rdy; rx_data_in = dat; clr_counters = clr;
    popm = rdy && q.size() > 0;
    if (popm) begin
      chk("pop_data", m_data, q[0][7:0]);
      chk("pop_flag", m_parity_flag, q[0][8]);
    end
    d = d && run_m;
    pe = pe && run_m;
    pb = pend_m || pe;
    acc = d && (q.size() < D || popm);
    if (popm) void'(q.pop_front());
    if (acc) q.push_back({pb, dat});
    if (clr) begin ovr_m = 0; par_m = 0; end
    if (d && !acc) ovr_m = ovr_m == 255 ? 255 : ovr_m + 1;
    if (d && pb) par_m = par_m == 255 ? 255 : par_m + 1;
    if (d) pend_m = 0;
    else if (pe) pend_m = 1;
    cyc();
    rx_done_tick_in = 0; parity_err_in = 0; clr_counters = 0; m_ready = 0;
    check_state();
  endtask

  task automatic count_ticks(input int cycles, output int cnt);
    cnt = 0;
    repeat (cycles) begin cyc(); cnt += int'(baud_clk_tick); end
  endtask

  task automatic wait_tick();
    int k = 0;
    while (!baud_clk_tick && k < 100) begin cyc(); k++; end
    chk("tick_seen", baud_clk_tick, 1);
  endtask

  task automatic drain();
    int k = 0;
    while (q.size() != 0 && k < 20) begin step(0, 0, 1, 8'h00, 0); k++; end
  endtask

  initial begin
    int t, dv, k;
    reset = 1; cfg_enable = 0; cfg_divisor = 3; clr_counters = 0;
    rx_done_tick_in = 0; parity_err_in = 0; rx_data_in = 0; m_ready = 0;
    repeat (2) cyc();
    chk("rst_tick", baud_clk_tick, 0);
    chk("rst_valid", m_valid, 0);
    chk("rst_level", fifo_level, 0);
    chk("rst_data", m_data, 0);
    chk("rst_flag", m_parity_flag, 0);
    chk("rst_ovr", overrun_cnt, 0);
    chk("rst_par", parity_err_cnt, 0);
    chk("rst_timeout", rx_timeout, 0);
    reset = 0;
    cyc();
    cfg_enable = 1;
    cyc();
    wait_tick();
    count_ticks(40, t);
    chk("tick_div3", t, 10);
    cfg_divisor = 0;
    cyc();
    count_ticks(10, t);
    chk("tick_div0", t, 10);
    repeat (3) begin
      dv = $urandom_range(1, 7);
      cfg_divisor = DW'(dv);
      wait_tick();
      count_ticks(6 * (dv + 1), t);
      chk("tick_rand", t, 6);
    end
    cfg_enable = 0;
    cyc();
    count_ticks(10, t);
    chk("tick_off", t, 0);
    cfg_enable = 1; cfg_divisor = 50;
    cyc();
    step(0, 1, 0, 8'h00, 0);
    repeat (19) step(0, 0, 0, 8'h00, 0);
    step(1, 0, 0, 8'hA5, 0);
    chk("a5_data", m_data, 8'hA5);
    chk("a5_flag", m_parity_flag, 1);
    chk("a5_par", parity_err_cnt, 1);
    step(1, 0, 0, 8'h3C, 0);
    step(0, 0, 1, 8'h00, 0);
    chk("3c_data", m_data, 8'h3C);
    chk("3c_flag", m_parity_flag, 0);
    step(0, 0, 1, 8'h00, 0);
    step(0, 0, 0, 8'h00, 1);
    for (int i = 1; i <= 4; i++) step(1, 0, 0, 8'(i), 0);
    step(1, 0, 0, 8'h05, 0);
    chk("ovr_level", fifo_level, 4);
    chk("ovr_cnt", overrun_cnt, 1);
    for (int i = 1; i <= 4; i++) begin
      chk("order", m_data, i);
      step(0, 0, 1, 8'h00, 0);
    end
    for (int i = 1; i <= 4; i++) step(1, 0, 0, 8'(8'h10 + i), 0);
    step(1, 0, 1, 8'h77, 0);
    chk("fullpop_level", fifo_level, 4);
    chk("fullpop_ovr", overrun_cnt, 1);
    repeat (3) step(0, 0, 1, 8'h00, 0);
    chk("last_77", m_data, 8'h77);
    step(0, 0, 1, 8'h00, 0);
    repeat (300) begin
      cfg_enable = $urandom_range(0, 19) != 0;
      step($urandom_range(0, 2) == 0, $urandom_range(0, 5) == 0, $urandom_range(0, 1) == 1,
           8'($urandom), $urandom_range(0, 39) == 0);
    end
    cfg_enable = 1;
    cyc();
    step(0, 0, 0, 8'h00, 1);
    while (q.size() < D) step(1, 0, 0, 8'($urandom), 0);
    repeat (256) step(1, 0, 0, 8'($urandom), 0);
    chk("ovr_sat", overrun_cnt, 255);
    repeat (256) step(1, 1, 0, 8'($urandom), 0);
    chk("par_sat", parity_err_cnt, 255);
    step(1, 0, 0, 8'h00, 1);
    chk("ovr_clr_inc", overrun_cnt, 1);
    chk("par_clr", parity_err_cnt, 0);
    drain();
    step(1, 0, 1, 8'h5A, 0);
    chk("empty_pushpop_level", fifo_level, 1);
    chk("empty_pushpop_data", m_data, 8'h5A);
    drain();
    step(0, 1, 0, 8'h00, 0);
    cfg_enable = 0;
    cyc();
    cyc();
    cfg_enable = 1;
    cyc();
    step(1, 0, 0, 8'h42, 0);
    chk("pend_off_flag", m_parity_flag, 0);
    drain();
`ifdef UART_RX_CTRL_TIMEOUT_EN
    cfg_divisor = 0;
    step(1, 0, 0, 8'h99, 0);
    k = 0;
    while (!rx_timeout && k < 1000) begin step(0, 0, 0, 8'h00, 0); k++; end
    chk("timeout_ticks", k, 640);
    step(0, 0, 1, 8'h00, 0);
    chk("timeout_clr", rx_timeout, 0);
`endif
    step(0, 1, 0, 8'h00, 0);
    step(1, 0, 0, 8'h66, 0);
    rx_done_tick_in = 1; rx_data_in = 8'h67; cfg_divisor = 0;
    #2 reset = 1;
    #1;
    chk("arst_tick", baud_clk_tick, 0);
    chk("arst_valid", m_valid, 0);
    chk("arst_level", fifo_level, 0);
    chk("arst_data", m_data, 0);
    chk("arst_ovr", overrun_cnt, 0);
    chk("arst_par", parity_err_cnt, 0);
    chk("arst_timeout", rx_timeout, 0);
    rx_done_tick_in = 0;
    q.delete(); ovr_m = 0; par_m = 0; pend_m = 0;
    cyc();
    reset = 0;
    cyc();
    step(1, 0, 0, 8'h10, 0);
    chk("post_rst_flag", m_parity_flag, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
